// File: rtl/filter_stream_capture.sv
// Captures DEPTH valid filter samples after an arm pulse, then replays them on a valid/ready stream.
// Optional drop counter enabled by defining FILTER_CAPTURE_DROP_CNT_EN.
module filter_stream_capture #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              arm,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic [DATA_W-1:0] rd_tdata,
    output logic              rd_tvalid,
    input  logic              rd_tready,
    output logic              rd_tlast,
    output logic              busy,
    output logic              done,
    output logic [15:0]       drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READOUT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en;
    logic last_wr;
    logic hs;
    logic final_hs;
    logic load;

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        last_wr  = 1'b0;
        final_hs = 1'b0;
        load     = 1'b0;
        hs       = rd_tvalid && rd_tready;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_tvalid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_IDX) begin
                        last_wr  = 1'b1;
                        state_nx = READOUT;
                    end
                end
            end
            READOUT: begin
                // One-entry prefetch: refill whenever the output slot empties.
                if (hs && rd_tlast) begin
                    final_hs = 1'b1;
                    state_nx = IDLE;
                end else if (!rd_tvalid || hs) begin
                    load = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_tdata  <= '0;
            rd_tvalid <= 1'b0;
            rd_tlast  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= final_hs;
            if (state == IDLE && arm) begin
                wr_ptr <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (last_wr) begin
                rd_ptr <= '0;
            end
            if (load) begin
                rd_tdata  <= mem[rd_ptr];
                rd_tlast  <= (rd_ptr == LAST_IDX);
                rd_tvalid <= 1'b1;
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end
            if (final_hs) begin
                rd_tvalid <= 1'b0;
                rd_tlast  <= 1'b0;
            end
        end
    end

    // Buffer contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

`ifdef FILTER_CAPTURE_DROP_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            drop_cnt <= '0;
        end else if (s_tvalid && state != CAPTURE && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_filter_stream_capture.sv
// Self-checking bench for filter_stream_capture: scenario table, queue model, reset and saturation sequences.
// Drop-count expectations follow FILTER_CAPTURE_DROP_CNT_EN.
module tb_filter_stream_capture;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              arm;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic [DATA_W-1:0] rd_tdata;
    logic              rd_tvalid;
    logic              rd_tready;
    logic              rd_tlast;
    logic              busy;
    logic              done;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_drop = 16'h0;

    typedef struct {
        int gap;
        int ready_pct;
        int pre;
        int ro;
        bit arm_mid;
        bit arm_final;
        bit cnt_data;
        int drop_inc;
    } vec_t;

    vec_t vecs[5];

    filter_stream_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .arm       (arm),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .rd_tdata  (rd_tdata),
        .rd_tvalid (rd_tvalid),
        .rd_tready (rd_tready),
        .rd_tlast  (rd_tlast),
        .busy      (busy),
        .done      (done),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] drop_add(input logic [15:0] c, input int n);
`ifdef FILTER_CAPTURE_DROP_CNT_EN
        int unsigned s;
        s = int'(c) + n;
        return (s > 32'd65535) ? 16'hFFFF : s[15:0];
`else
        return 16'h0000 + 16'(c & 16'h0) + 16'(n & 0);
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_tvalid"}, rd_tvalid, 0);
        check({tag, "_rd_tlast"}, rd_tlast, 0);
        check({tag, "_rd_tdata"}, rd_tdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic run_capture(input vec_t v);
        logic [DATA_W-1:0] q[$];
        logic [DATA_W-1:0] d;
        int sent;
        int cyc;
        int popped;
        int ncyc;
        for (int i = 0; i < v.pre; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'($urandom);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        arm      = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("busy_after_arm", busy, 1);
        sent = 0;
        cyc  = 0;
        while (sent < DEPTH) begin
            s_tvalid = ((cyc % v.gap) == 0);
            arm      = v.arm_mid && (cyc == 20);
            if (s_tvalid) begin
                d = v.cnt_data ? DATA_W'(sent) : DATA_W'($urandom);
                s_tdata = d;
                q.push_back(d);
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        arm      = 1'b0;
        check("tvalid_after_last_write", rd_tvalid, 0);
        check("busy_in_readout", busy, 1);
        popped = 0;
        ncyc   = 0;
        while (popped < DEPTH && ncyc < 5000) begin
            rd_tready = ($urandom_range(99) < v.ready_pct);
            s_tvalid  = (ncyc < v.ro);
            s_tdata   = DATA_W'($urandom);
            arm       = 1'b0;
            check("done_during_readout", done, 0);
            if (rd_tvalid) begin
                check("rd_tdata", rd_tdata, q[popped]);
                check("rd_tlast", rd_tlast, popped == DEPTH - 1);
            end
            if (rd_tvalid && rd_tready) begin
                popped++;
                if (popped == DEPTH && v.arm_final) arm = 1'b1;
            end
            ncyc++;
            @(negedge clk);
        end
        if (popped < DEPTH) begin
            errors++;
            $display("FAIL readout_timeout: got %0d entries required %0d", popped, DEPTH);
        end
        arm       = 1'b0;
        rd_tready = 1'b0;
        s_tvalid  = 1'b0;
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("tvalid_after_done", rd_tvalid, 0);
        check("tlast_after_done", rd_tlast, 0);
        if (v.ready_pct == 100) check("zero_bubble_cycles", ncyc, DEPTH + 1);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_no_restart", busy, 0);
        exp_drop = drop_add(exp_drop, v.drop_inc);
        check("drop_cnt", drop_cnt, exp_drop);
    endtask

    task automatic reset_mid(input bit in_readout, input int n);
        int cnt;
        int popped;
        int budget;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        cnt = in_readout ? DEPTH : n;
        for (int i = 0; i < cnt; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'(i);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        if (in_readout) begin
            rd_tready = 1'b1;
            popped = 0;
            budget = 0;
            while (popped < n && budget < 1000) begin
                if (rd_tvalid) begin
                    check("pre_reset_data", rd_tdata, popped);
                    popped++;
                end
                budget++;
                @(negedge clk);
            end
        end
        #2 arst_n = 1'b0;
        #1 check_reset_values(in_readout ? "rst_readout" : "rst_capture");
        exp_drop = 16'h0;
        @(negedge clk);
        arst_n    = 1'b1;
        rd_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
            check("idle_after_reset", busy, 0);
        end
    endtask

    initial begin
        vecs[0] = '{1, 100, 0, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{3, 50, 0, 0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1, 100, 5, 7, 1'b0, 1'b0, 1'b0, 12};
        vecs[3] = '{2, 70, 0, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{1, 100, 0, 0, 1'b0, 1'b0, 1'b1, 0};

        arst_n    = 1'b0;
        arm       = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        rd_tready = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_capture(vecs[i]);

        reset_mid(1'b0, 60);
        reset_mid(1'b1, 40);
        run_capture(vecs[4]);

        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'($urandom);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        exp_drop = drop_add(exp_drop, 70000);
        check("drop_saturated", drop_cnt, exp_drop);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        exp_drop = drop_add(exp_drop, 5);
        check("drop_holds", drop_cnt, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
